// File: rtl/sfifo_wb_pkg.sv
// Shared constants for the sfifo_wb_bridge slice: register word indices,
// STATUS bit positions, DOUT_CMD field positions and serializer FSM encodings.
// Latency: n/a (constants only). Backpressure: n/a.
package sfifo_wb_pkg;

  // Register word indices (wb_adr_i is already a word address)
  localparam logic [31:0] REG_BP_TICK   = 32'd0;
  localparam logic [31:0] REG_STATUS    = 32'd1;
  localparam logic [31:0] REG_SFIFO_DI  = 32'd2;
  localparam logic [31:0] REG_DOUT_CMD  = 32'd3;
  localparam logic [31:0] REG_DIN       = 32'd4;
  localparam logic [31:0] REG_MBOX_OBUF = 32'd5;
  localparam logic [31:0] REG_ADC_BASE  = 32'd8;

  // STATUS bit positions
  localparam int ST_SFIFO_EMPTY = 0;
  localparam int ST_SFIFO_FULL  = 1;
  localparam int ST_MBOX_FULL   = 2;
  localparam int ST_BUF_FULL    = 3;
  localparam int ST_SER_BUSY    = 4;
  localparam int ST_RD_TMO      = 5;
  localparam int ST_CNT_LSB     = 8;

  // DOUT_CMD fields
  localparam int DC_VALID   = 31;
  localparam int DC_LEVEL   = 30;
  localparam int DC_IDX_LSB = 24;
  localparam int DC_IDX_W   = 6;

  typedef enum logic [1:0] {
    SER_IDLE = 2'd0,
    SER_LOAD = 2'd1,
    SER_SEND = 2'd2
  } ser_state_t;

endpackage

// File: rtl/sfifo_wb_bridge_if.sv
// WISHBONE classic slave bus bundle used between the CPU side and sfifo_wb_bridge.
// Latency: n/a (wires only). Backpressure: slave withholds wb_ack_o to stall.
// Signals: cyc/stb/we/sel/adr/dat_i from master; dat_o/ack_o from slave.
interface sfifo_wb_bridge_if #(
  parameter int WB_AW = 6
);
  logic             wb_cyc_i;
  logic             wb_stb_i;
  logic             wb_we_i;
  logic [3:0]       wb_sel_i;
  logic [WB_AW-3:0] wb_adr_i;
  logic [31:0]      wb_dat_i;
  logic [31:0]      wb_dat_o;
  logic             wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/sfifo_mbox_ser.sv
// Mailbox word buffer (DEPTH x {sel,word}) feeding a byte serializer, LSB lane first.
// Latency: push -> first byte offered 2 cycles later (IDLE->LOAD->SEND).
// Backpressure: buf_full stops pushes; mbox_full_i stalls the current byte.
// Ports: clk/rst, push_vld/push_dat/push_sel, buf_full/buf_cnt/busy, mbox_wr_o/mbox_do_o/mbox_full_i.
module sfifo_mbox_ser
  import sfifo_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_vld,
  input  logic [31:0] push_dat,
  input  logic [3:0]  push_sel,
  output logic        buf_full,
  output logic [7:0]  buf_cnt,
  output logic        busy,
  output logic        mbox_wr_o,
  output logic [7:0]  mbox_do_o,
  input  logic        mbox_full_i
);
  localparam int AW = $clog2(DEPTH);

  logic [35:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, cnt;
  logic        buf_empty;

  ser_state_t  state;
  logic [31:0] word_q;
  logic [3:0]  sel_q;
  logic [1:0]  lane_q;

  assign cnt       = wr_ptr - rd_ptr;
  assign buf_full  = (cnt == (AW+1)'(DEPTH));
  assign buf_empty = (cnt == '0);
  assign buf_cnt   = 8'(cnt);
  assign busy      = (state != SER_IDLE);

  // The write strobe must see mbox_full_i in the same cycle, otherwise a byte
  // could land in a mailbox that has just filled; hence not registered.
  assign mbox_wr_o = (state == SER_SEND) & sel_q[lane_q] & ~mbox_full_i;
  assign mbox_do_o = word_q[{lane_q, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_ptr[AW-1:0]] <= {push_sel, push_dat};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= SER_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      word_q <= '0;
      sel_q  <= '0;
      lane_q <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + 1'b1;
      case (state)
        // A new word is only started while the mailbox has room, so words
        // queue in the buffer rather than sitting half-sent in the serializer.
        SER_IDLE: if (!buf_empty && !mbox_full_i) state <= SER_LOAD;
        SER_LOAD: begin
          {sel_q, word_q} <= mem[rd_ptr[AW-1:0]];
          rd_ptr          <= rd_ptr + 1'b1;
          lane_q          <= 2'd0;
          state           <= SER_SEND;
        end
        SER_SEND: begin
          // Unselected lanes are skipped; a selected lane advances only when written.
          if (!sel_q[lane_q] || !mbox_full_i) begin
            lane_q <= lane_q + 2'd1;
            if (lane_q == 2'd3) state <= SER_IDLE;
          end
        end
        default: state <= SER_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/sfifo_wb_bridge.sv
// WISHBONE slave: BP tick counter/sync, DOUT set/reset masks, DIN/ADC/STATUS reads, SFIFO pop, mailbox.
// Latency: ack 1 cycle after cyc&stb, single-cycle pulse, never back-to-back.
// Backpressure: ack withheld on SFIFO_DI while empty and on MBOX_OBUF while word buffer full.
// Ports: wb_clk_i/wb_rst_i, wb (slave modport), sfifo_*, mbox_*, sfifo_bp_tick_i, dout_set/rst_o, din_i, adc_i.
// Build option: define SFIFO_WB_RD_TMO_EN to give up an SFIFO_DI read after RD_TMO stall cycles.
module sfifo_wb_bridge
  import sfifo_wb_pkg::*;
#(
  parameter int WB_AW      = 6,
  parameter int WB_DW      = 32,
  parameter int SFIFO_DW   = 16,
  parameter int DOUT_N     = 16,
  parameter int DIN_W      = 32,
  parameter int ADC_W      = 12,
  parameter int ADC_CH     = 2,
  parameter int MBOX_DEPTH = 4,
  parameter int RD_TMO     = 1024
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  sfifo_wb_bridge_if.slave        wb,
  output logic                    sfifo_rd_o,
  input  logic                    sfifo_empty_i,
  input  logic                    sfifo_full_i,
  input  logic [SFIFO_DW-1:0]     sfifo_di,
  output logic                    mbox_wr_o,
  output logic [7:0]              mbox_do_o,
  input  logic                    mbox_full_i,
  input  logic                    sfifo_bp_tick_i,
  output logic [DOUT_N-1:0]       dout_set_o,
  output logic [DOUT_N-1:0]       dout_rst_o,
  input  logic [DIN_W-1:0]        din_i,
  input  logic [ADC_CH*ADC_W-1:0] adc_i
);
  logic [31:0]         adr_w;
  logic                ack_q;
  logic [WB_DW-1:0]    dat_q, rd_mux, status;
  logic                req, is_sfifo_rd, is_stat_rd, is_mbox_wr, is_dout_wr;
  logic                ack_go, sfifo_pop, mbox_push, dout_acc, tmo_hit, tmo_sticky;
  logic                buf_full, ser_busy;
  logic [7:0]          buf_cnt;
  logic [2:0]          bp_sync;
  logic                bp_p;
  logic [31:0]         bp_cnt;
  logic [DOUT_N-1:0]   pend_set, pend_rst, nxt_set, nxt_rst;
  logic [DC_IDX_W-1:0] dc_idx;

  assign adr_w       = 32'(wb.wb_adr_i[WB_AW-3:0]);
  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;

  // ack_q in the request term keeps acks from running back-to-back.
  assign req         = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign is_sfifo_rd = req & ~wb.wb_we_i & (adr_w == REG_SFIFO_DI);
  assign is_stat_rd  = req & ~wb.wb_we_i & (adr_w == REG_STATUS);
  assign is_mbox_wr  = req &  wb.wb_we_i & (adr_w == REG_MBOX_OBUF);
  assign is_dout_wr  = req &  wb.wb_we_i & (adr_w == REG_DOUT_CMD);

`ifdef SFIFO_WB_RD_TMO_EN
  localparam int TMO_W = $clog2(RD_TMO + 1);
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = is_sfifo_rd & sfifo_empty_i & (tmo_cnt == TMO_W'(RD_TMO));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)                                tmo_cnt <= '0;
    else if (is_sfifo_rd & sfifo_empty_i & ~tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
    else                                         tmo_cnt <= '0;
  end
`else
  // Timeout compiled out: the term is constant false, reads wait for data.
  assign tmo_hit = is_sfifo_rd & (RD_TMO < 0);
`endif

  assign sfifo_pop = is_sfifo_rd & ~sfifo_empty_i;
  assign mbox_push = is_mbox_wr & (wb.wb_sel_i != 4'd0) & ~buf_full;
  assign dc_idx    = wb.wb_dat_i[DC_IDX_LSB +: DC_IDX_W];
  assign dout_acc  = is_dout_wr & wb.wb_sel_i[3] & wb.wb_dat_i[DC_VALID];

  always_comb begin
    ack_go = req;
    if (is_sfifo_rd)     ack_go = ~sfifo_empty_i | tmo_hit;
    else if (is_mbox_wr) ack_go = (wb.wb_sel_i == 4'd0) | ~buf_full;
  end

  always_comb begin
    status                 = '0;
    status[ST_SFIFO_EMPTY] = sfifo_empty_i;
    status[ST_SFIFO_FULL]  = sfifo_full_i;
    status[ST_MBOX_FULL]   = mbox_full_i;
    status[ST_BUF_FULL]    = buf_full;
    status[ST_SER_BUSY]    = ser_busy;
    status[ST_RD_TMO]      = tmo_sticky;
    status[ST_CNT_LSB +: 8] = buf_cnt;
  end

  always_comb begin
    rd_mux = '0;
    if (adr_w == REG_BP_TICK)       rd_mux = bp_cnt;
    else if (adr_w == REG_STATUS)   rd_mux = status;
    else if (adr_w == REG_SFIFO_DI) rd_mux = tmo_hit ? '0 : (32'(sfifo_di) << (WB_DW - SFIFO_DW));
    else if (adr_w == REG_DIN)      rd_mux = 32'(din_i);
    for (int k = 0; k < ADC_CH; k++) begin
      if (adr_w == REG_ADC_BASE + 32'(k)) rd_mux = 32'(adc_i[k*ADC_W +: ADC_W]);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      sfifo_rd_o <= 1'b0;
      tmo_sticky <= 1'b0;
    end else begin
      ack_q      <= ack_go;
      dat_q      <= (ack_go & ~wb.wb_we_i) ? rd_mux : '0;
      sfifo_rd_o <= sfifo_pop;
      if (tmo_hit)         tmo_sticky <= 1'b1;
      else if (is_stat_rd) tmo_sticky <= 1'b0;
    end
  end

  // Tick arrives from another domain: two sync flops, third flop for edge detect.
  assign bp_p = bp_sync[1] & ~bp_sync[2];

  // Indices >= DOUT_N match no bit in the loop and are therefore dropped.
  always_comb begin
    nxt_set = bp_p ? '0 : pend_set;
    nxt_rst = bp_p ? '0 : pend_rst;
    for (int i = 0; i < DOUT_N; i++) begin
      if (dout_acc && dc_idx == DC_IDX_W'(i)) begin
        nxt_set[i] = wb.wb_dat_i[DC_LEVEL];
        nxt_rst[i] = ~wb.wb_dat_i[DC_LEVEL];
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      bp_sync    <= '0;
      bp_cnt     <= '0;
      pend_set   <= '0;
      pend_rst   <= '0;
      dout_set_o <= '0;
      dout_rst_o <= '0;
    end else begin
      bp_sync  <= {bp_sync[1:0], sfifo_bp_tick_i};
      pend_set <= nxt_set;
      pend_rst <= nxt_rst;
      if (bp_p) begin
        bp_cnt     <= bp_cnt + 32'd1;
        dout_set_o <= pend_set;
        dout_rst_o <= pend_rst;
      end
    end
  end

  sfifo_mbox_ser #(
    .DEPTH (MBOX_DEPTH)
  ) u_ser (
    .clk         (wb_clk_i),
    .rst         (wb_rst_i),
    .push_vld    (mbox_push),
    .push_dat    (wb.wb_dat_i),
    .push_sel    (wb.wb_sel_i),
    .buf_full    (buf_full),
    .buf_cnt     (buf_cnt),
    .busy        (ser_busy),
    .mbox_wr_o   (mbox_wr_o),
    .mbox_do_o   (mbox_do_o),
    .mbox_full_i (mbox_full_i)
  );
endmodule
